// File: rtl/idli_sqi_rbuf_m_if.sv
// Bundle of the SQI reorder-buffer control, write and read signals between
// the pad side (master) and the buffer (slave).
//
// Handshake: a write is announced by i_sqi_wr_en and its nibble follows on
// i_sqi_data one cycle later; a read pops o_sqi_data at any edge where
// i_sqi_rd_en=1 and o_sqi_valid=1, and o_sqi_valid acts as the read-side valid.
interface idli_sqi_rbuf_m_if #(
   parameter int WIDTH = 4
);
   localparam int CW = $clog2(WIDTH + 1);

   logic          i_sqi_clr;
   logic          i_sqi_mode;
   logic          i_sqi_wr_en;
   logic [3:0]    i_sqi_data;
   logic          i_sqi_rd_en;
   logic [3:0]    o_sqi_data;
   logic          o_sqi_valid;
   logic          o_sqi_full;
   logic [CW-1:0] o_sqi_count;
   logic          o_sqi_err;

   modport master (
      output i_sqi_clr, i_sqi_mode, i_sqi_wr_en, i_sqi_data, i_sqi_rd_en,
      input  o_sqi_data, o_sqi_valid, o_sqi_full, o_sqi_count, o_sqi_err
   );

   modport slave (
      input  i_sqi_clr, i_sqi_mode, i_sqi_wr_en, i_sqi_data, i_sqi_rd_en,
      output o_sqi_data, o_sqi_valid, o_sqi_full, o_sqi_count, o_sqi_err
   );
endinterface

// File: rtl/idli_sqi_rbuf_m.sv
// Nibble reorder buffer: circular store read back either LIFO (reversed)
// or FIFO (in order), with one-cycle-delayed write data and sticky error flag.
module idli_sqi_rbuf_m #(
   parameter int WIDTH = 4
) (
   input  logic                   i_sqi_gck,
   input  logic                   i_sqi_rst_n,
   idli_sqi_rbuf_m_if.slave       sqi
);
   typedef logic [3:0] sqi_data_t;

   localparam int           CW  = $clog2(WIDTH + 1);
   localparam int           PW  = $clog2(WIDTH);
   localparam logic [CW:0]  W_X = (CW + 1)'(WIDTH);
   localparam logic [CW-1:0] W_C = CW'(WIDTH);

   sqi_data_t     mem_q [WIDTH];
   logic [PW-1:0] head_q;
   logic [CW-1:0] count_q;
   logic          wr_pend_q;
   logic          mode_q;
   logic          err_q;

   // Modulo-WIDTH add; operands never exceed 2*WIDTH-1 so one subtract suffices.
   function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base,
                                              input logic [CW-1:0] off);
      logic [CW:0] s;
      s = {{(CW + 1 - PW){1'b0}}, base} + {1'b0, off};
      if (s >= W_X) s = s - W_X;
      return s[PW-1:0];
   endfunction

   logic          empty, full, push, pop, overflow, underflow, mem_we;
   logic [CW-1:0] top_off;
   logic [PW-1:0] push_slot, top_slot, rd_slot, head_inc, mem_wa;

   assign empty     = (count_q == '0);
   assign full      = (count_q == W_C);
   assign push      = wr_pend_q;
   assign pop       = sqi.i_sqi_rd_en && !empty;
   assign overflow  = push && full && !pop;
   assign underflow = sqi.i_sqi_rd_en && empty;

   assign top_off   = empty ? '0 : count_q - CW'(1);
   assign push_slot = wrap_add(head_q, count_q);
   assign top_slot  = wrap_add(head_q, top_off);
   assign head_inc  = wrap_add(head_q, CW'(1));
   assign rd_slot   = mode_q ? head_q : top_slot;

   // In LIFO a simultaneous push lands on the slot being popped.
   assign mem_we    = push && !sqi.i_sqi_clr && (!full || pop);
   assign mem_wa    = (pop && !mode_q) ? top_slot : push_slot;

   always_ff @(posedge i_sqi_gck) begin
      if (mem_we) mem_q[mem_wa] <= sqi.i_sqi_data;
   end

   always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
      if (!i_sqi_rst_n) begin
         head_q    <= '0;
         count_q   <= '0;
         wr_pend_q <= 1'b0;
         mode_q    <= 1'b0;
         err_q     <= 1'b0;
      end else if (sqi.i_sqi_clr) begin
         head_q    <= '0;
         count_q   <= '0;
         wr_pend_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         wr_pend_q <= sqi.i_sqi_wr_en;
         if (overflow || underflow) err_q <= 1'b1;
         if (push && empty) mode_q <= sqi.i_sqi_mode;
         if (pop && mode_q) head_q <= head_inc;
         if (push && !pop && !full) count_q <= count_q + CW'(1);
         else if (pop && !push)     count_q <= count_q - CW'(1);
      end
   end

   assign sqi.o_sqi_data  = empty ? 4'h0 : mem_q[rd_slot];
   assign sqi.o_sqi_valid = !empty;
   assign sqi.o_sqi_full  = full;
   assign sqi.o_sqi_count = count_q;
   assign sqi.o_sqi_err   = err_q;
endmodule

// File: doc/idli_sqi_rbuf_m.md
# idli_sqi_rbuf_m

Parametrised nibble-serial reorder buffer for the SQI datapath. It supersedes the fixed 4-nibble rotating buffer and adds:
- configurable depth;
- a selectable read order, either reversed (LIFO) or in-order (FIFO);
- independent read handshaking, occupancy and full flags;
- overflow/underflow error reporting;
- asynchronous reset.

It sits between the SQI pad interface and the core, where it buffers address and data nibbles whose order must be reversed or preserved.

## Interface

Parameters:
- WIDTH, 4, depth in sqi_data_t (4b) entries; legal range 2..16.

Ports:
- i_sqi_gck  in  1  SQI clock; all state updates on rising edge.
- i_sqi_rst_n  in  1  asynchronous active-low reset.
- i_sqi_clr  in  1  synchronous clear; empties the buffer and clears the error flag.
- i_sqi_mode  in  1  read order: 0 = reverse (LIFO), 1 = in-order (FIFO); latched at first push into an empty buffer.
- i_sqi_wr_en  in  1  write enable, one cycle ahead of the data.
- i_sqi_data  in  4  write nibble (sqi_data_t), valid the cycle after i_sqi_wr_en.
- i_sqi_rd_en  in  1  pop the current o_sqi_data at this edge.
- o_sqi_data  out  4  current read nibble; 4'h0 when empty.
- o_sqi_valid  out  1  count != 0.
- o_sqi_full  out  1  count == WIDTH.
- o_sqi_count  out  $clog2(WIDTH+1)  number of stored entries.
- o_sqi_err  out  1  sticky; set on overflow or underflow.

## Operation

**State**
- WIDTH-entry nibble array (not reset).
- head pointer (oldest entry) and count.
- wr_pend_q: registered i_sqi_wr_en.
- mode_q: latched read order.
- err_q: sticky error flag.

**Index arithmetic** (all modulo WIDTH, with explicit wrap; WIDTH need not be a power of two)
- Push slot = head+count.
- FIFO read slot = head.
- LIFO read slot = head+count-1.

**Push**
- A push occurs at an edge where wr_pend_q=1; i_sqi_data is captured at that edge.
- When count==0, mode_q <= i_sqi_mode at the same edge. Otherwise i_sqi_mode is ignored.

**Pop**
- A pop occurs at an edge where i_sqi_rd_en=1 and count!=0.
- FIFO pop: head++, count--.
- LIFO pop: count-- only.

**Push and pop at the same edge**, count!=0
- count is unchanged. This is legal even when full.
- FIFO: write to the push slot, head++.
- LIFO: the new nibble overwrites the popped top slot.

**Overflow**
- Push with count==WIDTH and no pop: the nibble is dropped, err_q <= 1, and state is otherwise unchanged.

**Underflow**
- i_sqi_rd_en with count==0: no pop occurs and err_q <= 1.
- A simultaneous push still completes.

**Clear**
- i_sqi_clr has priority over push and pop.
- It sets head, count, wr_pend_q and err_q to 0.
- It discards any pending write, so the nibble on the following cycle is not captured.

**Reset** (asynchronous assertion)
- Same effect as clear, plus mode_q <= 0.
- Valid mid-transfer; any partial write sequence is lost.

## Timing

**Reset values**
- o_sqi_data=0, o_sqi_valid=0, o_sqi_full=0, o_sqi_count=0, o_sqi_err=0.

**Write latency**
- i_sqi_wr_en sampled at edge E.
- Data captured at edge E+1.
- o_sqi_count, o_sqi_valid and o_sqi_data reflect the new entry after E+1.
- Back-to-back wr_en gives one push per cycle.

**Read**
- o_sqi_data and the flags are combinational from registered state only; there is no input-to-output combinational path.
- The consumer samples o_sqi_data in the cycle it asserts i_sqi_rd_en.
- The next entry appears after that edge.

**Throughput**
- One push and one pop per cycle, sustained.
- Turnaround between the last push and the first pop needs no idle cycle.

**Error flag**
- o_sqi_err rises the cycle after the offending edge.
- It holds until clear or reset.

## Test plan

- **LIFO order.** Reset, WIDTH=4, mode=0. wr_en for 4 cycles with data 1,2,3,4 following one cycle later. Then rd_en for 4 cycles. Required: o_sqi_data reads 4,3,2,1; count goes 4→0; full=1 only while count is 4.
- **FIFO order with wrap.** mode=1. Push A,B,C; pop A; push D,E; pop all. Required: B,C,D,E, with head wrapping past index 3 and err=0.
- **Overflow.** WIDTH=4, push 5 nibbles 1..5 without reads. Required: count=4, err=1 the cycle after the 5th capture, and LIFO readout 4,3,2,1 (nibble 5 dropped).
- **Simultaneous push/pop.** Full buffer in FIFO mode; push 9 while popping. Required: count stays 4, popped value is the oldest entry, 9 is read last. Repeat in LIFO mode: the popped value is the top entry, and the next o_sqi_data is 9.
- **Underflow and mode latch.** rd_en on an empty buffer. Required: err=1, count=0, o_sqi_data=0. Then toggle i_sqi_mode while non-empty. Required: read order unchanged.
- **Reset/clear mid-operation.** Assert i_sqi_rst_n=0 asynchronously mid-write (between wr_en and data), then release; separately, pulse clr while count=3. Required: all outputs 0 immediately on reset assertion and the pending nibble is not captured; after clr, count=0 and err=0 on the next cycle.
